pipe_latch_skid: RTL
====================

# pipe_latch_skid

Parametrised pipeline-stage latch with valid/ready handshake, a two-entry skid buffer, flush-to-bubble, and a delayed reset indicator. It sits between any two pipeline stages (fetch/decode, decode/execute, …) and carries NUM_CH payload channels (e.g. PC and instruction). When empty or flushed it presents a per-channel NOP pattern, so downstream logic always sees a well-defined bubble. Upstream stalls are derived from the handshake rather than a separate stall input, and full throughput is kept at one transfer per cycle.

## Interface
- DATA_W, 16, width of one payload channel
- NUM_CH, 2, number of payload channels
- NOP_VEC, {16'hffff, 16'h0800}, packed NUM_CH*DATA_W bubble pattern; channel 0 is in the LSBs
- CNT_W, 16, performance counter width (used only with PIPE_LATCH_PERF_EN)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds valid payload
- in_ready  out  1  registered; the latch can accept this cycle
- in_data  in  NUM_CH*DATA_W  upstream payload
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  the main entry holds valid payload
- out_ready  in  1  downstream consumes this cycle
- out_data  out  NUM_CH*DATA_W  main entry payload, or NOP_VEC when not valid
- out_rst  out  1  delayed reset indicator for the next stage
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  present only with PIPE_LATCH_PERF_EN
- bubble_cnt  out  CNT_W  present only with PIPE_LATCH_PERF_EN

## Operation
- Transfers: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- State machine:
  - EMPTY: accept → ONE, input written to main.
  - ONE, accept & consume → ONE, main ← input.
  - ONE, accept only → TWO, skid ← input.
  - ONE, consume only → EMPTY.
  - ONE, neither → ONE.
  - TWO, consume → ONE, main ← skid.
  - TWO, no consume → TWO.
- In state TWO no input is accepted, because in_ready is 0.
- in_ready is registered: it is 1 in EMPTY and ONE, 0 in TWO. Its next value is computed from the next state.
- out_valid is 1 in ONE and TWO. occupancy tracks the state: 0, 1, 2.
- out_data equals main when out_valid is 1, otherwise NOP_VEC. The main register is also loaded with NOP_VEC whenever it empties.
- Flush has priority over every other event:
  - Next state is EMPTY and main ← NOP_VEC.
  - Any input offered in the same cycle is dropped, even if in_ready was 1.
  - A consume in the flush cycle still counts as a transfer to downstream.
- out_rst is a flop asynchronously forced to 1 while rst is low. It loads 0 on each edge after release, so it stays high for exactly one cycle after deassertion.
- Reset values:
  - state EMPTY, occupancy 0
  - in_ready 1, out_valid 0
  - out_data NOP_VEC, main and skid NOP_VEC
  - out_rst 1, counters 0
- Reset mid-operation discards all entries immediately, with no wait for a clock edge.

## Timing
- Latency: payload accepted at edge N appears on out_data after edge N (one cycle).
- Throughput: one transfer per cycle in ONE while out_ready stays 1.
- Skid: after out_ready drops, one extra beat is still absorbed. in_ready falls one cycle later.
- Drain: out_ready rising in TWO makes the skid payload visible the next cycle, with in_ready back to 1 at the same time.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Configuration
- PIPE_LATCH_PERF_EN defined:
  - stall_cnt increments every cycle with out_valid & ~out_ready.
  - bubble_cnt increments every cycle with ~out_valid.
  - Both saturate at all-ones and are cleared only by rst.
- PIPE_LATCH_PERF_EN undefined: the counter logic and both ports are absent, and the behaviour is otherwise identical.

## Structure
- Package pipe_latch_pkg holds:
  - the state typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - occupancy constants
  - a NUM_CH*DATA_W packing helper
- Sub-module pipe_latch_slot holds one payload entry:
  - write enable
  - asynchronous active-low reset to a NOP_VEC parameter
  - synchronous clear to NOP_VEC
- pipe_latch_skid instantiates the slot twice, as main and skid.

## Test plan
- Reset release: rst low, then high with in_valid=0.
  - Expect out_rst=1 for exactly one cycle after release, then 0.
  - Expect out_data=0xffff_0800, out_valid=0, in_ready=1.
- Streaming: out_ready=1 and in_data 0x0000_1111, 0x0002_2222, 0x0004_3333 on consecutive cycles.
  - Expect the same values on out_data one cycle later, with occupancy 1 throughout.
- Skid: hold out_ready=0 while sending A=0x0010_AAAA then B=0x0012_BBBB.
  - Expect occupancy 2, in_ready 0, out_data A.
  - Raise out_ready: expect B next cycle and in_ready=1.
- Flush in TWO with in_valid=1 offering C.
  - Expect occupancy 0 and out_data=0xffff_0800 next cycle.
  - C must never appear on out_data.
- Async reset mid-stream: pull rst low between edges while in TWO.
  - Expect out_valid=0, occupancy 0 and out_rst=1 immediately, with no clock edge.
- Counters (PIPE_LATCH_PERF_EN, CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles.
  - Expect stall_cnt to saturate at 15.
  - Expect bubble_cnt to equal the number of empty cycles before the fill.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types and helpers for the pipeline-stage latch: state encoding,
// occupancy constants and the default two-channel payload packer.
package pipe_latch_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned OCC_W      = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } latch_state_e;

  // Default payload layout; channel 0 sits in the LSBs.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] ch1;
    logic [DEF_DATA_W-1:0] ch0;
  } def_payload_t;

  function automatic def_payload_t pack_payload(input logic [DEF_DATA_W-1:0] ch1,
                                                input logic [DEF_DATA_W-1:0] ch0);
    def_payload_t p;
    p.ch1 = ch1;
    p.ch0 = ch0;
    return p;
  endfunction

  function automatic logic [OCC_W-1:0] state_occupancy(input latch_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ONE:     occ = OCC_ONE;
      TWO:     occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_latch_slot.sv
// One payload entry of the latch: write enable, synchronous clear to the
// bubble pattern, asynchronous active-low reset to the bubble pattern.
module pipe_latch_slot #(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    NOP_VEC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over write so a flush never lets fresh data in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= NOP_VEC;
    end else if (clr) begin
      q <= NOP_VEC;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage latch with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and delayed reset output. Optional counters: PIPE_LATCH_PERF_EN.
module pipe_latch_skid
  import pipe_latch_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 2,
  parameter logic [NUM_CH*DATA_W-1:0] NOP_VEC =
    (NUM_CH*DATA_W)'(pack_payload(16'hffff, 16'h0800)),
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_rst,
  output logic [OCC_W-1:0]         occupancy
`ifdef PIPE_LATCH_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  localparam int unsigned BUS_W = NUM_CH * DATA_W;

  latch_state_e     state_q, state_d;
  logic             accept, consume;
  logic             main_we, main_clr, skid_we, skid_clr;
  logic [BUS_W-1:0] main_din, main_q, skid_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // main is cleared whenever it empties, so it doubles as out_data.
  assign out_data = main_q;

  pipe_latch_slot #(.W(BUS_W), .NOP_VEC(NOP_VEC)) u_main (
    .clk (clk),
    .rst (rst),
    .we  (main_we),
    .clr (main_clr),
    .d   (main_din),
    .q   (main_q)
  );

  pipe_latch_slot #(.W(BUS_W), .NOP_VEC(NOP_VEC)) u_skid (
    .clk (clk),
    .rst (rst),
    .we  (skid_we),
    .clr (skid_clr),
    .d   (in_data),
    .q   (skid_q)
  );

  // State and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= OCC_EMPTY;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != TWO);
      out_valid <= (state_d != EMPTY);
      occupancy <= state_occupancy(state_d);
    end
  end

  // Next state and slot controls; flush overrides every handshake event.
  always_comb begin
    state_d  = state_q;
    main_we  = 1'b0;
    main_clr = 1'b0;
    main_din = in_data;
    skid_we  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_we = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_we = 1'b1;
          end else if (accept) begin
            state_d = TWO;
            skid_we = 1'b1;
          end else if (consume) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          if (consume) begin
            state_d  = ONE;
            main_we  = 1'b1;
            main_din = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // High while reset is held and for the first cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rst <= 1'b1;
    end else begin
      out_rst <= 1'b0;
    end
  end

`ifdef PIPE_LATCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating stall and bubble counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
